// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage.
// Latches operands on a start pulse, counts a fixed latency, then commits
// the 64-bit product or the quotient/remainder pair into HI/LO. Also serves
// mthi/mtlo writes and mfhi/mflo reads.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        mf_sel,
    output logic        busy,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic [1:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // Arithmetic on the latched operands
    logic signed [63:0] a_sext;
    logic signed [63:0] b_sext;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic signed [31:0] sa;
    logic signed [31:0] sb_safe;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] ub_safe;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;
    logic               res_write;

    assign a_sext = {{32{a_reg[31]}}, a_reg};
    assign b_sext = {{32{b_reg[31]}}, b_reg};
    assign prod_s = a_sext * b_sext;
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

    assign div_zero = (b_reg == 32'd0);
    assign div_ovf  = (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);

    // Divisors are forced to 1 in the zero/overflow cases so the divider
    // never sees an undefined operation; those cases are overridden below.
    assign sa      = a_reg;
    assign sb_safe = (div_zero || div_ovf) ? 32'sd1 : b_reg;
    assign quot_s  = sa / sb_safe;
    assign rem_s   = sa % sb_safe;
    assign ub_safe = div_zero ? 32'd1 : b_reg;
    assign quot_u  = a_reg / ub_safe;
    assign rem_u   = a_reg % ub_safe;

    // Select the result for the latched operation and whether it lands
    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_write = 1'b1;
        case (op_reg)
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'd2: begin
                if (div_zero) begin
                    res_write = 1'b0;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            default: begin
                if (div_zero) begin
                    res_write = 1'b0;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
        endcase
    end

    // Sequencer FSM: launch, latency count, commit, and mthi/mtlo writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            op_reg    <= 2'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        op_reg    <= md_op;
                        a_reg     <= A;
                        b_reg     <= B;
                        count_reg <= md_op[1] ? DIV_LOAD : MULT_LOAD;
                    end else if (mt_we) begin
                        if (mt_sel) begin
                            hi_reg <= mt_data;
                        end else begin
                            lo_reg <= mt_data;
                        end
                    end
                end
                RUN: begin
                    if (count_reg == 4'd1) begin
                        state_reg <= IDLE;
                        count_reg <= 4'd0;
                        if (res_write) begin
                            hi_reg <= res_hi;
                            lo_reg <= res_lo;
                        end
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= 4'd0;
                end
            endcase
        end
    end

    // Busy covers the launch cycle combinationally so the stall takes effect at once
    assign busy    = start || (state_reg == RUN);
    assign mf_data = mf_sel ? hi_reg : lo_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus random operations
// compared against an arithmetic reference model of HI/LO.
module tb_md_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_data;
    logic        mf_sel;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    md_sequencer #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .mt_we  (mt_we),
        .mt_sel (mt_sel),
        .mt_data(mt_data),
        .mf_sel (mf_sel),
        .busy   (busy),
        .mf_data(mf_data),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: apply the architectural rules for one operation
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        int          sa;
        int          sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            2'd0: begin
                ps = longint'(sa) * longint'(sb);
                hi_m = ps[63:32];
                lo_m = ps[31:0];
            end
            2'd1: begin
                pu = 64'(a) * 64'(b);
                hi_m = pu[63:32];
                lo_m = pu[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    // divide by zero leaves HI/LO alone
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000;
                    hi_m = 32'd0;
                end else begin
                    lo_m = 32'(sa / sb);
                    hi_m = 32'(sa % sb);
                end
            end
            default: begin
                if (b != 32'd0) begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
        endcase
    endtask

    task automatic mt_write(input logic sel, input logic [31:0] data);
        mt_we   = 1'b1;
        mt_sel  = sel;
        mt_data = data;
        tick();
        mt_we = 1'b0;
        if (sel) hi_m = data;
        else     lo_m = data;
        $display("mt write sel=%0d data=%h", sel, data);
    endtask

    // One md operation; optionally inject a second start or an mt write
    // during RUN cycle k, or an mt write in the launch cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int start_at, input int mt_at, input bit mt_same);
        int          n;
        logic [31:0] hi_pre;
        logic [31:0] lo_pre;
        n      = (op < 2'd2) ? MULT_N : DIV_N;
        hi_pre = hi_m;
        lo_pre = lo_m;
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        if (mt_same) begin
            mt_we   = 1'b1;
            mt_sel  = 1'($urandom);
            mt_data = $urandom;
        end
        #1;
        check("busy_launch", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        mt_we = 1'b0;
        md_op = 2'($urandom);
        A     = $urandom;
        B     = $urandom;
        model_op(op, a, b);
        for (int k = 1; k <= n; k++) begin
            if (k == start_at) begin
                start = 1'b1;
                md_op = 2'($urandom);
                A     = $urandom;
                B     = $urandom;
            end
            if (k == mt_at) begin
                mt_we   = 1'b1;
                mt_sel  = 1'($urandom);
                mt_data = $urandom;
            end
            #1;
            check("busy_run", 32'(busy), 32'd1);
            mf_sel = 1'(k);
            #1;
            check("mf_pre_op", mf_data, mf_sel ? hi_pre : lo_pre);
            tick();
            start = 1'b0;
            mt_we = 1'b0;
        end
        #1;
        check("busy_done", 32'(busy), 32'd0);
        check("hi_result", hi, hi_m);
        check("lo_result", lo, lo_m);
        mf_sel = 1'b1;
        #1;
        check("mf_hi_result", mf_data, hi_m);
        $display("op=%0d A=%h B=%h -> hi=%h lo=%h (model hi=%h lo=%h)",
                 op, a, b, hi, lo, hi_m, lo_m);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b0;
        start   = 1'b0;
        md_op   = 2'd0;
        A       = 32'd0;
        B       = 32'd0;
        mt_we   = 1'b0;
        mt_sel  = 1'b0;
        mt_data = 32'd0;
        mf_sel  = 1'b0;
        hi_m    = 32'd0;
        lo_m    = 32'd0;

        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_mf", mf_data, 32'd0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        tick();

        // mthi write
        mt_write(1'b1, 32'h1234_5678);
        mf_sel = 1'b1;
        #1;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'd0);
        check("mthi_mf", mf_data, 32'h1234_5678);

        // Directed arithmetic
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFA);
        run_op(2'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0);
        check("multu_hi_const", hi, 32'h0000_0002);
        check("multu_lo_const", lo, 32'hFFFF_FFFA);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        run_op(2'd3, 32'd7, 32'd2, 0, 0, 1'b0);
        check("divu_lo_const", lo, 32'd3);
        check("divu_hi_const", hi, 32'd1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        // Divide by zero
        mt_write(1'b1, 32'hAAAA_0000);
        mt_write(1'b0, 32'h0000_5555);
        run_op(2'd3, 32'd9, 32'd0, 0, 0, 1'b0);
        check("divz_hi", hi, 32'hAAAA_0000);
        check("divz_lo", lo, 32'h0000_5555);
        run_op(2'd2, 32'hFFFF_0001, 32'd0, 0, 0, 1'b0);

        // Ignored requests
        run_op(2'd0, 32'h0001_0003, 32'hFFFF_0007, 3, 0, 1'b0);
        run_op(2'd3, 32'd1000, 32'd7, 0, 4, 1'b0);
        run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0, 1'b1);

        // Reset in the middle of a mult
        start = 1'b1;
        md_op = 2'd0;
        A     = 32'h0000_0123;
        B     = 32'h0000_0456;
        tick();
        start = 1'b0;
        for (int k = 1; k < 4; k++) tick();
        reset = 1'b0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        check("rst_mid_mf", mf_data, 32'd0);
        tick();
        start = 1'b1;
        #1;
        check("rst_start_busy", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        #1;
        check("rst_state_hold", 32'(busy), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_hi", hi, 32'd0);
            check("post_rst_lo", lo, 32'd0);
        end
        $display("reset mid-run: hi=%h lo=%h busy=%0d", hi, lo, busy);

        // Random operations with occasional mt writes
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                mt_write(1'($urandom), $urandom);
                mf_sel = 1'b0;
                #1;
                check("rand_mt_lo", mf_data, lo_m);
                check("rand_mt_hi", hi, hi_m);
            end
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(5, 0))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(15, 1));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu launches, holds operands, and counts the fixed operation latency.
- Commits results to its internal HI/LO registers and services mthi/mtlo writes and mfhi/mflo reads.
- Its busy output is the E_Busy signal the stall unit uses to hold md/mf/mt instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle launch pulse from the E-stage md instruction.
- md_op  input  2  operation: 0=mult, 1=multu, 2=div, 3=divu; sampled only when start=1.
- A  input  32  rs operand (forwarded value); sampled with start.
- B  input  32  rt operand (forwarded value); sampled with start.
- mt_we  input  1  mthi/mtlo write strobe.
- mt_sel  input  1  write target: 0=LO, 1=HI.
- mt_data  input  32  write data for mthi/mtlo.
- mf_sel  input  1  read select: 0=LO, 1=HI.
- busy  output  1  start OR (state==RUN); drives E_Busy.
- mf_data  output  32  combinational read of the selected HI/LO register.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, counter=0, HI=0, LO=0, operand/op latches=0.
  - Outputs during and after reset: busy=0, mf_data=0. busy may still go high combinationally if start is driven while reset is asserted; state does not change.
  - Reset asserted mid-RUN aborts the operation; HI/LO return to 0 and the result is never written.
- State machine:
  - IDLE -> RUN on start=1. Latch md_op, A and B. Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - RUN: decrement counter each cycle. When the counter reaches 1, commit the result to HI/LO at that edge and go to IDLE.
- Timing:
  - Start in cycle T makes busy high combinationally in T.
  - busy is then high in T+1..T+N (N = MULT_CYCLES or DIV_CYCLES) and low in T+N+1.
  - The new HI/LO values are visible on mf_data/hi/lo from T+N+1.
- Arithmetic:
  - mult: {HI,LO} = signed(A) * signed(B), 64-bit.
  - multu: {HI,LO} = unsigned(A) * unsigned(B), 64-bit.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - Division by zero (latched B=0): HI and LO stay unchanged, and the full busy latency is still observed.
  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
  - Results are computed from the latched operands, so changes on A, B or md_op after start have no effect.
- mthi/mtlo:
  - mt_we=1 in IDLE with start=0 writes mt_data to the register chosen by mt_sel at that edge; visible next cycle.
  - mt_we while RUN is ignored; the stall unit guarantees this case does not occur.
  - start and mt_we in the same cycle: start wins and mt_we is ignored.
- start while RUN: ignored. Latches, counter and busy are unaffected.
- mf_data: pure mux of HI/LO, no added latency. A read while RUN returns the pre-operation value.

Test Plan:
- Reset release, then mt_we=1, mt_sel=1, mt_data=0x12345678 -> next cycle hi=0x12345678, lo=0. With mf_sel=1, mf_data=0x12345678.
- Signed multiply: start, md_op=0, A=0xFFFFFFFE (-2), B=3 -> busy high in start cycle plus 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- Signed divide: div A=-7 (0xFFFFFFF9), B=2 -> busy high for 1+10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1.
- Divide by zero: preload HI=0xAAAA0000, LO=0x5555; divu A=9, B=0 -> busy for the full 11 cycles; hi/lo unchanged afterwards.
- Ignored requests: second start at RUN cycle 3 -> completion time and result unchanged. mt_we during RUN -> no write. start and mt_we in the same IDLE cycle -> only the md result lands.
- Reset mid-RUN: assert reset at RUN cycle 4 of a mult -> busy=0, hi=lo=0 immediately. After release, no late commit occurs.
